load_store_unit: RTL and testbench

MEM-stage load/store unit sitting directly upstream of the 512-byte big-endian data memory. It accepts one load/store request at a time from the EX stage and issues word-aligned MemRead/MemWrite strobes to the memory. It performs sign/zero extension for sub-word loads and read-modify-write for sub-word stores. Misaligned and out-of-range accesses are flagged without touching memory.

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a big-endian word-addressed data memory.
// Handles sub-word loads with extension, sub-word stores via read-modify-write, and fault detection.
module load_store_unit #(
  parameter int MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  input  logic [31:0] dm_read_data
);

  typedef enum logic [2:0] {
    IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP
  } state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t      state, state_n;
  logic [31:0] addr_q, data_q, word_q;
  logic [2:0]  op_q;
  logic        accept, misalign, out_of_range, req_fault;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [4:0]  sh_b, sh_h;
  logic [31:0] ext, merged;

  assign accept       = req_valid & req_ready;
  assign out_of_range = addr >= 32'(MEM_BYTES);
  assign req_fault    = misalign | out_of_range;

  // Alignment requirement depends on the access width of the incoming op
  always_comb begin
    misalign = 1'b0;
    case (mem_op)
      OP_LW, OP_SW:         misalign = addr[1:0] != 2'b00;
      OP_LH, OP_LHU, OP_SH: misalign = addr[0];
      default:              misalign = 1'b0;
    endcase
  end

  // Big-endian lane shifts: offset 0 is the most significant lane
  assign sh_b   = {~addr_q[1:0], 3'b000};
  assign sh_h   = {~addr_q[1], 4'b0000};
  assign lane_b = 8'(dm_read_data >> sh_b);
  assign lane_h = 16'(dm_read_data >> sh_h);

  // Extend the addressed lane of the read word according to the load type
  always_comb begin
    ext = 32'd0;
    case (op_q)
      OP_LW:   ext = dm_read_data;
      OP_LH:   ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ext = {16'd0, lane_h};
      OP_LB:   ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ext = {24'd0, lane_b};
      default: ext = 32'd0;
    endcase
  end

  // Replace only the addressed lane of the captured word for sub-word stores
  always_comb begin
    merged = word_q;
    if (op_q == OP_SB)
      merged = (word_q & ~(32'h0000_00FF << sh_b))
             | ({24'd0, data_q[7:0]} << sh_b);
    else
      merged = (word_q & ~(32'h0000_FFFF << sh_h))
             | ({16'd0, data_q[15:0]} << sh_h);
  end

  assign dm_address    = {addr_q[31:2], 2'b00};
  assign dm_write_data = (op_q == OP_SW) ? data_q : merged;
  assign dm_mem_read   = (state == LOAD) | (state == RMW_READ);
  assign dm_mem_write  = (state == STORE) | (state == RMW_WRITE);
  assign req_ready     = state == IDLE;
  assign resp_valid    = state == RESP;

  // Next-state selection; new requests are only considered in IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault)
            state_n = RESP;
          else if (mem_op == OP_SW)
            state_n = STORE;
          else if (mem_op == OP_SH || mem_op == OP_SB)
            state_n = RMW_READ;
          else
            state_n = LOAD;
        end
      end
      LOAD:      state_n = RESP;
      STORE:     state_n = RESP;
      RMW_READ:  state_n = RMW_WRITE;
      RMW_WRITE: state_n = RESP;
      RESP:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // State, request latches and registered response fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      op_q      <= 3'd0;
      word_q    <= 32'd0;
      load_data <= 32'd0;
      fault     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= addr;
        data_q <= store_data;
        op_q   <= mem_op;
        if (req_fault) begin
          load_data <= 32'd0;
          fault     <= 1'b1;
        end
      end
      case (state)
        LOAD: begin
          load_data <= ext;
          fault     <= 1'b0;
        end
        STORE, RMW_WRITE: begin
          load_data <= 32'd0;
          fault     <= 1'b0;
        end
        RMW_READ: word_q <= dm_read_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory behind the DUT, and a
// byte-level reference model that predicts every response.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        fault;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [31:0] dm_read_data;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [512];
  logic [7:0] ref_mem [512];
  int         ri, wi;

  load_store_unit #(.MEM_BYTES(512)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_op(mem_op), .addr(addr), .store_data(store_data),
    .resp_valid(resp_valid), .load_data(load_data), .fault(fault),
    .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
    .dm_read_data(dm_read_data)
  );

  always #5 clk = ~clk;

  assign ri = int'(dm_address & 32'h1FC);
  assign dm_read_data = {mem[ri], mem[ri+1], mem[ri+2], mem[ri+3]};

  always @(posedge clk) begin
    wi = int'(dm_address & 32'h1FC);
    if (dm_mem_write) begin
      mem[wi]   <= dm_write_data[31:24];
      mem[wi+1] <= dm_write_data[23:16];
      mem[wi+2] <= dm_write_data[15:8];
      mem[wi+3] <= dm_write_data[7:0];
    end
  end

  // Reference: spec rules over a byte array, big-endian
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] ed,
                       output logic ef, output int el, output int er,
                       output int ew);
    int i, v;
    bit mis;
    i = int'(a & 32'h1FF);
    mis = ((op == 0 || op == 5) && (a % 4) != 0) ||
          ((op == 1 || op == 2 || op == 6) && (a % 2) != 0);
    ed = 0; ef = 0; el = 0; er = 0; ew = 0;
    if (a >= 512 || mis) begin
      ef = 1; el = 1;
    end else if (op <= 4) begin
      el = 2; er = 1;
      if (op == 0) begin
        ed = {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
      end else if (op <= 2) begin
        v = ref_mem[i] * 256 + ref_mem[i+1];
        if (op == 1 && v > 32767) v -= 65536;
        ed = v;
      end else begin
        v = ref_mem[i];
        if (op == 3 && v > 127) v -= 256;
        ed = v;
      end
    end else if (op == 5) begin
      el = 2; ew = 1;
      ref_mem[i] = d[31:24]; ref_mem[i+1] = d[23:16];
      ref_mem[i+2] = d[15:8]; ref_mem[i+3] = d[7:0];
    end else begin
      el = 3; er = 1; ew = 1;
      if (op == 6) begin
        ref_mem[i] = d[15:8]; ref_mem[i+1] = d[7:0];
      end else begin
        ref_mem[i] = d[7:0];
      end
    end
  endtask

  // Drive one request and observe latency, response and strobe activity
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] od,
                       output logic of, output int ol, output int nr,
                       output int nw, output int nb, output int na);
    int n;
    od = 'x; of = 'x; ol = -1; nr = 0; nw = 0; nb = 0; na = 0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) return;
    req_valid = 1; mem_op = op; addr = a; store_data = d;
    @(posedge clk);
    #1 req_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (dm_mem_read) nr++;
      if (dm_mem_write) nw++;
      if (dm_mem_read && dm_mem_write) nb++;
      if ((dm_mem_read || dm_mem_write) &&
          dm_address !== {a[31:2], 2'b00}) na++;
      if (resp_valid) begin
        ol = k; od = load_data; of = fault;
        break;
      end
    end
  endtask

  logic [31:0] od, ed;
  logic        of, ef;
  int          ol, nr, nw, nb, na, el, er, ew;

  task automatic test_reset();
    reset = 1; req_valid = 0; mem_op = 0; addr = 0; store_data = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, load_data, fault, dm_mem_read,
         dm_mem_write} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: rdy=%b rv=%b ld=%h f=%b rd=%b wr=%b, want 1 0 0 0 0 0",
               req_ready, resp_valid, load_data, fault, dm_mem_read,
               dm_mem_write);
    end
    reset = 0;
  endtask

  task automatic test_basic();
    logic [2:0]  ops [10] = '{5, 0, 3, 4, 1, 2, 7, 0, 6, 0};
    logic [31:0] as  [10] = '{'h10, 'h10, 'h11, 'h11, 'h12, 'h10,
                              'h13, 'h10, 'h10, 'h10};
    logic [31:0] ds  [10] = '{'hDEADBEEF, 0, 0, 0, 0, 0,
                              'h12345677, 0, 'h0000CAFE, 0};
    for (int t = 0; t < 10; t++) begin
      model(ops[t], as[t], ds[t], ed, ef, el, er, ew);
      issue(ops[t], as[t], ds[t], od, of, ol, nr, nw, nb, na);
      total++;
      if ({od, of, ol, nr, nw, nb, na} !== {ed, ef, el, er, ew, 32'd0, 32'd0}) begin
        bad++;
        $display("FAIL basic op=%0d a=%h: got d=%h f=%b lat=%0d rd=%0d wr=%0d both=%0d badaddr=%0d want d=%h f=%b lat=%0d rd=%0d wr=%0d",
                 ops[t], as[t], od, of, ol, nr, nw, nb, na, ed, ef, el, er, ew);
      end
    end
  endtask

  task automatic test_fault();
    logic [2:0]  ops [3] = '{0, 6, 5};
    logic [31:0] as  [3] = '{'h12, 'h11, 'h200};
    int diff;
    for (int t = 0; t < 3; t++) begin
      model(ops[t], as[t], 32'hFFFF_FFFF, ed, ef, el, er, ew);
      issue(ops[t], as[t], 32'hFFFF_FFFF, od, of, ol, nr, nw, nb, na);
      total++;
      if ({od, of, ol, nr, nw} !== {ed, ef, el, er, ew}) begin
        bad++;
        $display("FAIL fault op=%0d a=%h: got d=%h f=%b lat=%0d rd=%0d wr=%0d want d=%h f=%b lat=%0d rd=%0d wr=%0d",
                 ops[t], as[t], od, of, ol, nr, nw, ed, ef, el, er, ew);
      end
    end
    diff = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) diff++;
    total++;
    if (diff !== 0) begin
      bad++;
      $display("FAIL fault_mem: got %0d differing bytes, want 0", diff);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1; mem_op = 3'd7; addr = 32'h10; store_data = 32'hFF;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    total++;
    if ({dm_mem_read, dm_mem_write} !== 2'b10) begin
      bad++;
      $display("FAIL rmw_read_phase: got rd=%b wr=%b, want 1 0",
               dm_mem_read, dm_mem_write);
    end
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, dm_mem_read, dm_mem_write, load_data,
         fault} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_abort: rdy=%b rv=%b rd=%b wr=%b ld=%h f=%b, want 1 0 0 0 0 0",
               req_ready, resp_valid, dm_mem_read, dm_mem_write, load_data,
               fault);
    end
    model(0, 32'h10, 0, ed, ef, el, er, ew);
    issue(0, 32'h10, 0, od, of, ol, nr, nw, nb, na);
    total++;
    if ({od, of, ol} !== {ed, ef, el}) begin
      bad++;
      $display("FAIL reset_prior_value: got d=%h f=%b lat=%0d want d=%h f=%b lat=%0d",
               od, of, ol, ed, ef, el);
    end
  endtask

  task automatic test_back_to_back();
    int n, busy_bad;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    model(5, 32'h40, 32'h0BADF00D, ed, ef, el, er, ew);
    req_valid = 1; mem_op = 3'd5; addr = 32'h40; store_data = 32'h0BADF00D;
    @(posedge clk);
    ol = -1; nw = 0; nr = 0; busy_bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (req_ready !== 1'b0) busy_bad++;
      if (dm_mem_read) nr++;
      if (dm_mem_write) nw++;
      if (resp_valid) begin
        ol = k; of = fault;
        break;
      end
      mem_op = 3'($urandom);
      addr = $urandom_range(0, 511);
      store_data = $urandom;
    end
    mem_op = 3'd0; addr = 32'h40; store_data = 32'd0;
    total++;
    if ({ol, nr, nw, of, busy_bad} !== {el, er, ew, ef, 32'd0}) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d rd=%0d wr=%0d f=%b busy_ready=%0d want lat=%0d rd=%0d wr=%0d f=%b busy_ready=0",
               ol, nr, nw, of, busy_bad, el, er, ew, ef);
    end
    model(0, 32'h40, 0, ed, ef, el, er, ew);
    issue(0, 32'h40, 0, od, of, ol, nr, nw, nb, na);
    total++;
    if ({od, of, ol} !== {ed, ef, el}) begin
      bad++;
      $display("FAIL b2b_second: got d=%h f=%b lat=%0d want d=%h f=%b lat=%0d",
               od, of, ol, ed, ef, el);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, d;
    int diff;
    for (int t = 0; t < 80; t++) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(512, 1023)
                                      : $urandom_range(0, 511);
      d = $urandom;
      model(op, a, d, ed, ef, el, er, ew);
      issue(op, a, d, od, of, ol, nr, nw, nb, na);
      total++;
      if ({od, of, ol, nr, nw, nb, na} !== {ed, ef, el, er, ew, 32'd0, 32'd0}) begin
        bad++;
        $display("FAIL random op=%0d a=%h d=%h: got d=%h f=%b lat=%0d rd=%0d wr=%0d both=%0d badaddr=%0d want d=%h f=%b lat=%0d rd=%0d wr=%0d",
                 op, a, d, od, of, ol, nr, nw, nb, na, ed, ef, el, er, ew);
      end
    end
    diff = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) diff++;
    total++;
    if (diff !== 0) begin
      bad++;
      $display("FAIL random_mem: got %0d differing bytes, want 0", diff);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    test_reset();
    test_basic();
    test_fault();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
